// File: rtl/pipe_pkg.sv
// Shared pipeline types for the decode-stage hazard controller.
// Scoreboard entry layout and common widths.
package pipe_pkg;

  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              v;
    logic              wr;
    logic              ld;
    logic [ADDR_W-1:0] dst;
  } sb_t;

  function automatic logic sb_live(sb_t e);
    return e.v & e.wr & (e.dst != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_control_if.sv
// ID-stage request bundle and the control
// signals returned to fetch and the pipe regs.
interface hazard_control_if #(
  parameter int ADDR_W = pipe_pkg::ADDR_W
);
  logic              id_valid;
  logic [ADDR_W-1:0] id_addra;
  logic [ADDR_W-1:0] id_addrb;
  logic              id_usea;
  logic              id_useb;
  logic              id_isbranch;
  logic              id_writereg;
  logic              id_readmem;
  logic [ADDR_W-1:0] id_regdest;
  logic              id_selpcsource;
  logic              stall;
  logic              bubble;
  logic              flush;
  logic              redirect_ok;

  modport master (
    output id_valid, id_addra, id_addrb,
    output id_usea, id_useb, id_isbranch,
    output id_writereg, id_readmem,
    output id_regdest, id_selpcsource,
    input  stall, bubble, flush, redirect_ok
  );

  modport slave (
    input  id_valid, id_addra, id_addrb,
    input  id_usea, id_useb, id_isbranch,
    input  id_writereg, id_readmem,
    input  id_regdest, id_selpcsource,
    output stall, bubble, flush, redirect_ok
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones.
// Used for stall and flush statistics.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  // count up on inc, hold once full
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/hazard_control.sv
// Decode-stage sequencing: EX/MEM scoreboard,
// load-use and branch-operand interlocks.
module hazard_control
  import pipe_pkg::*;
#(
  parameter int ADDR_W = pipe_pkg::ADDR_W,
  parameter int CNT_W  = pipe_pkg::CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  hazard_control_if.slave  hc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  sb_t ex_q;
  sb_t mem_q;

  logic [ADDR_W-1:0] ex_dst;
  logic [ADDR_W-1:0] mem_dst;
  logic ex_live;
  logic mem_live;
  logic ex_hit;
  logic mem_hit;
  logic load_use;
  logic br_haz;
  logic stall_w;
  logic redir_w;

  assign ex_dst  = ADDR_W'(ex_q.dst);
  assign mem_dst = ADDR_W'(mem_q.dst);

  // hazard detection and redirect gating
  always_comb begin
    ex_live  = sb_live(ex_q);
    mem_live = sb_live(mem_q);
    ex_hit   = (hc.id_usea & (hc.id_addra == ex_dst))
             | (hc.id_useb & (hc.id_addrb == ex_dst));
    mem_hit  = (hc.id_usea & (hc.id_addra == mem_dst))
             | (hc.id_useb & (hc.id_addrb == mem_dst));
    load_use = hc.id_valid & ex_live & ex_q.ld & ex_hit;
    br_haz   = hc.id_valid & hc.id_isbranch
             & ((ex_live & ex_hit)
             | (mem_live & mem_q.ld & mem_hit));
    stall_w  = load_use | br_haz;
    redir_w  = hc.id_valid & hc.id_selpcsource & ~stall_w;
  end

  assign hc.stall       = stall_w;
  assign hc.bubble      = stall_w;
  assign hc.redirect_ok = redir_w;
  assign hc.flush       = redir_w;

  // advance scoreboard; stalled or empty ID inserts a bubble
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else begin
      mem_q <= ex_q;
      if (hc.id_valid && !stall_w) begin
        ex_q.v   <= 1'b1;
        ex_q.wr  <= hc.id_writereg;
        ex_q.ld  <= hc.id_readmem;
        ex_q.dst <= pipe_pkg::ADDR_W'(hc.id_regdest);
      end else begin
        ex_q <= '0;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (stall_w),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (redir_w),
    .q     (flush_cnt)
  );

endmodule
